// File: rtl/rm_lane_scheduler.sv
// rm_lane_scheduler: front-end scheduler for the runtime-monitor lane pool.
// Buffers (pc, opcode) requests in a small FIFO and grants the head entry to
// the first free lane found scanning upward from a round-robin pointer.
// Busy lanes are freed by lane_release_i or by a per-lane watchdog after
// TIMEOUT busy cycles (TIMEOUT = 0 disables the watchdog).
// VLEN is the instruction PC width.
// Optional build macro: RM_SCHED_STATS_EN enables the saturating grant and
// stall counters; without it alloc_count_o and stall_cycles_o read 0.

module rm_lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int TIMEOUT     = 64,
    parameter int VLEN        = 64,
    parameter int LANE_W      = $clog2(NUM_LANES)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [VLEN-1:0]                  req_pc_i,
    input  logic [6:0]                       req_opcode_i,
    input  logic [NUM_LANES-1:0]             lane_release_i,
    output logic                             alloc_valid_o,
    output logic [LANE_W-1:0]                alloc_lane_o,
    output logic [VLEN-1:0]                  alloc_pc_o,
    output logic [6:0]                       alloc_opcode_o,
    output logic [NUM_LANES-1:0]             lane_busy_o,
    output logic [NUM_LANES-1:0]             timeout_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o,
    output logic [31:0]                      alloc_count_o,
    output logic [31:0]                      stall_cycles_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

    logic [VLEN+6:0]        fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [LANE_W-1:0]      rr_ptr;
    logic [NUM_LANES-1:0]   busy;
    logic [TMR_W-1:0]       timer [NUM_LANES];

    logic                   ready;
    logic                   push;
    logic                   dispatch;
    logic                   sel_found;
    logic [LANE_W-1:0]      sel_lane;
    logic [LANE_W-1:0]      cand;
    logic [NUM_LANES-1:0]   busy_next;
    logic [NUM_LANES-1:0]   timeout_next;

    // Ready looks only at the registered occupancy, so a pop never frees a slot in the same cycle.
    assign ready    = (count < DEPTH_C);
    assign push     = req_valid_i && ready;
    assign dispatch = (count != '0) && sel_found;

    assign req_ready_o   = ready;
    assign lane_busy_o   = busy;
    assign queue_count_o = count;

    // Round-robin pick: first free lane at or after rr_ptr, wrapping past the last lane.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = LANE_W'((int'(rr_ptr) + i) % NUM_LANES);
            if (!sel_found && !busy[cand]) begin
                sel_found = 1'b1;
                sel_lane  = cand;
            end
        end
    end

    // Next busy vector: releases first, then watchdog expiry (release wins), then the new grant.
    always_comb begin
        busy_next    = busy & ~lane_release_i;
        timeout_next = '0;
        if (TIMEOUT > 0) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (busy[k] && !lane_release_i[k] && (timer[k] == TMR_LAST)) begin
                    busy_next[k]    = 1'b0;
                    timeout_next[k] = 1'b1;
                end
            end
        end
        if (dispatch) begin
            busy_next[sel_lane] = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_pc_i, req_opcode_i};
        end
    end

    // FIFO pointers, occupancy, lane state and registered grant outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            rr_ptr         <= '0;
            busy           <= '0;
            timeout_o      <= '0;
            alloc_valid_o  <= 1'b0;
            alloc_lane_o   <= '0;
            alloc_pc_o     <= '0;
            alloc_opcode_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (dispatch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, dispatch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            busy      <= busy_next;
            timeout_o <= timeout_next;

            alloc_valid_o <= dispatch;
            if (dispatch) begin
                rr_ptr         <= (sel_lane == LANE_LAST) ? '0 : sel_lane + 1'b1;
                alloc_lane_o   <= sel_lane;
                alloc_pc_o     <= fifo_mem[rd_ptr][VLEN+6:7];
                alloc_opcode_o <= fifo_mem[rd_ptr][6:0];
            end
        end
    end

    // Per-lane watchdog timers: zero on grant, count every busy cycle.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (rst_i) begin
                timer[k] <= '0;
            end else if (dispatch && (sel_lane == LANE_W'(k))) begin
                timer[k] <= '0;
            end else if (busy[k]) begin
                timer[k] <= timer[k] + 1'b1;
            end
        end
    end

`ifdef RM_SCHED_STATS_EN
    logic [31:0] alloc_cnt;
    logic [31:0] stall_cnt;
    logic        stall;

    assign stall = (count != '0) && (&busy);

    // Saturating statistics counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (dispatch && (alloc_cnt != '1)) begin
                alloc_cnt <= alloc_cnt + 1'b1;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign alloc_count_o  = alloc_cnt;
    assign stall_cycles_o = stall_cnt;
`else
    assign alloc_count_o  = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_rm_lane_scheduler.sv
// Testbench for rm_lane_scheduler: directed scenarios with hand-derived
// expectations plus a randomized run checked against a queue-based model.
// Built with TIMEOUT = 8 so watchdog behaviour is reachable quickly.

module tb_rm_lane_scheduler;

    localparam int NL = 4;
    localparam int QD = 4;
    localparam int TO = 8;
    localparam int VL = 64;

`ifdef RM_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [VL-1:0]  req_pc_i = '0;
    logic [6:0]     req_opcode_i = '0;
    logic [NL-1:0]  lane_release_i = '0;
    logic           alloc_valid_o;
    logic [1:0]     alloc_lane_o;
    logic [VL-1:0]  alloc_pc_o;
    logic [6:0]     alloc_opcode_o;
    logic [NL-1:0]  lane_busy_o;
    logic [NL-1:0]  timeout_o;
    logic [2:0]     queue_count_o;
    logic [31:0]    alloc_count_o;
    logic [31:0]    stall_cycles_o;

    rm_lane_scheduler #(
        .NUM_LANES  (NL),
        .QUEUE_DEPTH(QD),
        .TIMEOUT    (TO),
        .VLEN       (VL)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_pc_i       (req_pc_i),
        .req_opcode_i   (req_opcode_i),
        .lane_release_i (lane_release_i),
        .alloc_valid_o  (alloc_valid_o),
        .alloc_lane_o   (alloc_lane_o),
        .alloc_pc_o     (alloc_pc_o),
        .alloc_opcode_o (alloc_opcode_o),
        .lane_busy_o    (lane_busy_o),
        .timeout_o      (timeout_o),
        .queue_count_o  (queue_count_o),
        .alloc_count_o  (alloc_count_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending queue, per-lane grant edge, round-robin start lane.
    logic [VL+6:0]  mq[$];
    bit             m_busy [NL];
    longint         m_gedge [NL];
    longint         edge_n = 0;
    int             m_rr = 0;
    bit             m_accepted = 1'b0;
    longint         m_alloc = 0;
    longint         m_stall = 0;
    logic           e_valid = 1'b0;
    logic [1:0]     e_lane = '0;
    logic [VL-1:0]  e_pc = '0;
    logic [6:0]     e_op = '0;
    logic [NL-1:0]  e_busy = '0;
    logic [NL-1:0]  e_tmo = '0;
    int             e_count = 0;
    bit             e_ready = 1'b1;

    task automatic model_edge();
        int n;
        bit found;
        int lane;
        logic [VL+6:0] ent;
        edge_n++;
        m_accepted = 1'b0;
        if (rst_i) begin
            mq.delete();
            for (int k = 0; k < NL; k++) m_busy[k] = 1'b0;
            m_rr = 0;
            e_valid = 1'b0; e_lane = '0; e_pc = '0; e_op = '0; e_tmo = '0;
            m_alloc = 0; m_stall = 0;
        end else begin
            n = mq.size();
            found = 1'b0;
            lane = 0;
            for (int i = 0; i < NL; i++) begin
                if (!found && !m_busy[(m_rr + i) % NL]) begin
                    found = 1'b1;
                    lane = (m_rr + i) % NL;
                end
            end
            if (n > 0 && !found) m_stall++;
            e_tmo = '0;
            for (int k = 0; k < NL; k++) begin
                if (m_busy[k]) begin
                    if (lane_release_i[k]) m_busy[k] = 1'b0;
                    else if (edge_n - m_gedge[k] == TO) begin
                        m_busy[k] = 1'b0;
                        e_tmo[k] = 1'b1;
                    end
                end
            end
            e_valid = 1'b0;
            if (n > 0 && found) begin
                ent = mq.pop_front();
                m_busy[lane] = 1'b1;
                m_gedge[lane] = edge_n;
                m_rr = (lane + 1) % NL;
                e_valid = 1'b1;
                e_lane = lane[1:0];
                e_pc = ent[VL+6:7];
                e_op = ent[6:0];
                m_alloc++;
            end
            if (req_valid_i && n < QD) begin
                mq.push_back({req_pc_i, req_opcode_i});
                m_accepted = 1'b1;
            end
        end
        for (int k = 0; k < NL; k++) e_busy[k] = m_busy[k];
        e_count = mq.size();
        e_ready = (mq.size() < QD);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        lane_release_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        lane_release_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        vectors++;
        if (alloc_valid_o !== 1'b0 || lane_busy_o !== 4'b0 || timeout_o !== 4'b0 ||
            queue_count_o !== 3'd0 || req_ready_o !== 1'b1 || alloc_lane_o !== 2'd0 ||
            alloc_pc_o !== '0 || alloc_opcode_o !== 7'd0 ||
            alloc_count_o !== 32'd0 || stall_cycles_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state got valid=%b busy=%b tmo=%b cnt=%0d rdy=%b lane=%0d pc=%h op=%h ac=%0d sc=%0d, want all 0 with rdy=1",
                     alloc_valid_o, lane_busy_o, timeout_o, queue_count_o, req_ready_o,
                     alloc_lane_o, alloc_pc_o, alloc_opcode_o, alloc_count_o, stall_cycles_o);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid_i = 1'b1; req_pc_i = 64'h1000; req_opcode_i = 7'h33;
        tick();
        req_valid_i = 1'b0;
        vectors++;
        if (alloc_valid_o !== 1'b0 || queue_count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL single_queued got valid=%b cnt=%0d, want valid=0 cnt=1", alloc_valid_o, queue_count_o);
        end
        tick();
        vectors++;
        if (alloc_valid_o !== 1'b1 || alloc_lane_o !== 2'd0 || alloc_pc_o !== 64'h1000 ||
            alloc_opcode_o !== 7'h33 || lane_busy_o !== 4'b0001 || queue_count_o !== 3'd0) begin
            miscompares++;
            $display("FAIL single_grant got valid=%b lane=%0d pc=%h op=%h busy=%b cnt=%0d, want 1 0 1000 33 0001 0",
                     alloc_valid_o, alloc_lane_o, alloc_pc_o, alloc_opcode_o, lane_busy_o, queue_count_o);
        end
        tick();
        vectors++;
        if (alloc_valid_o !== 1'b0 || lane_busy_o !== 4'b0001 ||
            alloc_count_o !== (STATS ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL single_pulse got valid=%b busy=%b ac=%0d, want valid=0 busy=0001 ac=%0d",
                     alloc_valid_o, lane_busy_o, alloc_count_o, STATS ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1'b1;
            req_pc_i = 64'h2000 + 64'(4 * i);
            req_opcode_i = 7'(8'h10 + i);
            tick();
            if (i >= 1) begin
                vectors++;
                if (alloc_valid_o !== 1'b1 || alloc_lane_o !== 2'(i - 1) ||
                    alloc_pc_o !== 64'h2000 + 64'(4 * (i - 1))) begin
                    miscompares++;
                    $display("FAIL b2b_grant%0d got valid=%b lane=%0d pc=%h, want 1 %0d %h",
                             i - 1, alloc_valid_o, alloc_lane_o, alloc_pc_o, i - 1, 64'h2000 + 64'(4 * (i - 1)));
                end
            end
        end
        req_valid_i = 1'b0;
        tick();
        vectors++;
        if (alloc_valid_o !== 1'b0 || lane_busy_o !== 4'b1111 || queue_count_o !== 3'd1 ||
            stall_cycles_o !== (STATS ? 32'd1 : 32'd0) || alloc_count_o !== (STATS ? 32'd4 : 32'd0)) begin
            miscompares++;
            $display("FAIL b2b_stall got valid=%b busy=%b cnt=%0d sc=%0d ac=%0d, want 0 1111 1 %0d %0d",
                     alloc_valid_o, lane_busy_o, queue_count_o, stall_cycles_o, alloc_count_o,
                     STATS ? 1 : 0, STATS ? 4 : 0);
        end
    endtask

    task automatic test_full_release();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_pc_i = 64'h3000 + 64'(4 * i);
            req_opcode_i = 7'h13;
            tick();
        end
        vectors++;
        if (req_ready_o !== 1'b0 || queue_count_o !== 3'd4 || lane_busy_o !== 4'b1111) begin
            miscompares++;
            $display("FAIL full_queue got rdy=%b cnt=%0d busy=%b, want 0 4 1111", req_ready_o, queue_count_o, lane_busy_o);
        end
        req_pc_i = 64'h3020;
        lane_release_i = 4'b0100;
        tick();
        lane_release_i = '0;
        vectors++;
        if (req_ready_o !== 1'b0 || queue_count_o !== 3'd4 || lane_busy_o !== 4'b1011 || alloc_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release got rdy=%b cnt=%0d busy=%b valid=%b, want 0 4 1011 0",
                     req_ready_o, queue_count_o, lane_busy_o, alloc_valid_o);
        end
        tick();
        req_valid_i = 1'b0;
        vectors++;
        if (alloc_valid_o !== 1'b1 || alloc_lane_o !== 2'd2 || alloc_pc_o !== 64'h3010 ||
            req_ready_o !== 1'b1 || queue_count_o !== 3'd3 || lane_busy_o !== 4'b1110 || timeout_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL full_regrant got valid=%b lane=%0d pc=%h rdy=%b cnt=%0d busy=%b tmo=%b, want 1 2 3010 1 3 1110 0001",
                     alloc_valid_o, alloc_lane_o, alloc_pc_o, req_ready_o, queue_count_o, lane_busy_o, timeout_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        req_valid_i = 1'b1; req_pc_i = 64'h4000; req_opcode_i = 7'h03;
        tick();
        req_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            vectors++;
            if (lane_busy_o !== 4'b0001 || timeout_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL tmo_busy_c%0d got busy=%b tmo=%b, want 0001 0000", c, lane_busy_o, timeout_o);
            end
        end
        tick();
        vectors++;
        if (lane_busy_o !== 4'b0000 || timeout_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL tmo_expire got busy=%b tmo=%b, want 0000 0001", lane_busy_o, timeout_o);
        end
        tick();
        vectors++;
        if (timeout_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL tmo_pulse got tmo=%b, want 0000", timeout_o);
        end
    endtask

    task automatic test_release_vs_timeout();
        apply_reset();
        req_valid_i = 1'b1; req_pc_i = 64'h4100; req_opcode_i = 7'h23;
        tick();
        req_pc_i = 64'h4104;
        tick();
        req_valid_i = 1'b0;
        repeat (8) tick();
        vectors++;
        if (lane_busy_o !== 4'b0010 || timeout_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL rvt_pre got busy=%b tmo=%b, want 0010 0001", lane_busy_o, timeout_o);
        end
        lane_release_i = 4'b0010;
        tick();
        lane_release_i = '0;
        vectors++;
        if (lane_busy_o !== 4'b0000 || timeout_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL rvt_same_edge got busy=%b tmo=%b, want 0000 0000", lane_busy_o, timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid_i = 1'b1;
            req_pc_i = 64'h5100 + 64'(4 * i);
            req_opcode_i = 7'h6f;
            tick();
        end
        req_valid_i = 1'b0;
        vectors++;
        if (queue_count_o !== 3'd3 || lane_busy_o !== 4'b1111) begin
            miscompares++;
            $display("FAIL mid_pre got cnt=%0d busy=%b, want 3 1111", queue_count_o, lane_busy_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        vectors++;
        if (queue_count_o !== 3'd0 || lane_busy_o !== 4'b0000 || alloc_valid_o !== 1'b0 ||
            timeout_o !== 4'b0000 || req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got cnt=%0d busy=%b valid=%b tmo=%b rdy=%b, want 0 0000 0 0000 1",
                     queue_count_o, lane_busy_o, alloc_valid_o, timeout_o, req_ready_o);
        end
        req_valid_i = 1'b1; req_pc_i = 64'h5000; req_opcode_i = 7'h37;
        tick();
        req_valid_i = 1'b0;
        tick();
        vectors++;
        if (alloc_valid_o !== 1'b1 || alloc_lane_o !== 2'd0 || alloc_pc_o !== 64'h5000 || timeout_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_restart got valid=%b lane=%0d pc=%h tmo=%b, want 1 0 5000 0000",
                     alloc_valid_o, alloc_lane_o, alloc_pc_o, timeout_o);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid_i || m_accepted) begin
                req_valid_i = ($urandom_range(0, 9) < 6);
                req_pc_i = {$urandom(), $urandom()};
                req_opcode_i = 7'($urandom());
            end
            for (int k = 0; k < NL; k++) lane_release_i[k] = ($urandom_range(0, 7) == 0);
            rst_i = ($urandom_range(0, 599) == 0);
            tick();
            vectors++;
            if (alloc_valid_o !== e_valid || (e_valid && (alloc_lane_o !== e_lane ||
                alloc_pc_o !== e_pc || alloc_opcode_o !== e_op))) begin
                miscompares++;
                $display("FAIL rnd_grant c=%0d got valid=%b lane=%0d pc=%h op=%h, want %b %0d %h %h",
                         c, alloc_valid_o, alloc_lane_o, alloc_pc_o, alloc_opcode_o, e_valid, e_lane, e_pc, e_op);
            end
            vectors++;
            if (lane_busy_o !== e_busy || timeout_o !== e_tmo) begin
                miscompares++;
                $display("FAIL rnd_lanes c=%0d got busy=%b tmo=%b, want %b %b", c, lane_busy_o, timeout_o, e_busy, e_tmo);
            end
            vectors++;
            if (queue_count_o !== 3'(e_count) || req_ready_o !== e_ready) begin
                miscompares++;
                $display("FAIL rnd_queue c=%0d got cnt=%0d rdy=%b, want %0d %b", c, queue_count_o, req_ready_o, e_count, e_ready);
            end
            vectors++;
            if (alloc_count_o !== (STATS ? m_alloc[31:0] : 32'd0) ||
                stall_cycles_o !== (STATS ? m_stall[31:0] : 32'd0)) begin
                miscompares++;
                $display("FAIL rnd_stats c=%0d got ac=%0d sc=%0d, want %0d %0d", c, alloc_count_o, stall_cycles_o,
                         STATS ? m_alloc : 0, STATS ? m_stall : 0);
            end
        end
        rst_i = 1'b0;
        req_valid_i = 1'b0;
        lane_release_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_release();
        test_timeout();
        test_release_vs_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit reached before completion, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

endmodule
